// File: rtl/desc_ring_fetch_pkg.sv
// Shared descriptor-ring types and AXI constants used by the CSR, fetch and DMA blocks.
package desc_ring_fetch_pkg;

   localparam int DESC_BYTES = 16;
   localparam int DESC_BEATS = 4;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [7:0] AXI_LEN_DESC   = 8'(DESC_BEATS - 1);

   localparam int CTRL_ALGO_SEL_BIT = 2;
   localparam int CTRL_ENC_DEC_BIT  = 3;

   // Word 0 sits in the low bits so beat n of the burst lands in word n.
   typedef struct packed {
      logic [31:0] user;
      logic [31:0] ctrl;
      logic [31:0] len;
      logic [31:0] src_addr;
   } desc_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_RDATA,
      ST_PRESENT,
      ST_ERROR
   } fetch_state_e;

endpackage

// File: rtl/desc_ring_fetch_if.sv
// AXI4 read channels toward memory plus the descriptor valid/ready channel toward the DMA.
interface desc_ring_fetch_if
   import desc_ring_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;

   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   logic                  desc_valid;
   logic                  desc_ready;
   desc_t                 desc;

   modport master (
      output araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready,
      output desc_valid, desc,
      input  desc_ready
   );

   modport slave (
      input  araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready,
      input  desc_valid, desc,
      output desc_ready
   );

endinterface

// File: rtl/desc_ring_fetch.sv
// Descriptor ring fetch: one 4-beat AXI read per entry, min 7 cycles/descriptor at zero-wait.
// Backpressure: descriptor held valid and stable until desc_ready; no new AR while one is in flight.
module desc_ring_fetch
   import desc_ring_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int PTR_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_enable,
   input  logic             i_ring_init,
   input  logic [31:0]      i_ring_base,
   input  logic [31:0]      i_ring_size,
   input  logic [PTR_W-1:0] i_sw_tail_ptr,
   output logic [PTR_W-1:0] o_hw_head_ptr,
   output logic             o_fetch_err,
   output logic             o_busy,
   desc_ring_fetch_if.master bus
);

   fetch_state_e          state;
   logic [PTR_W-1:0]      head;
   logic [1:0]            beat_cnt;
   logic [31:0]           word [DESC_BEATS];
   logic                  burst_err;
   logic                  discard;
   logic                  init_pend;

   logic [PTR_W-1:0]      size_eff;
   logic [PTR_W-1:0]      head_inc;
   logic [PTR_W-1:0]      head_adv;
   logic                  cfg_bad;
   logic                  beat_bad;
   logic                  beat_last;
   logic                  abort_req;
   logic                  init_any;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic                  unused_size_hi;

   assign size_eff       = i_ring_size[PTR_W-1:0];
   assign unused_size_hi = ^i_ring_size[31:PTR_W];
   assign head_inc       = head + PTR_W'(1);
   assign head_adv       = (head_inc == size_eff) ? '0 : head_inc;

   assign cfg_bad    = (size_eff == '0) || (i_sw_tail_ptr >= size_eff) || (i_ring_base[3:0] != 4'h0);
   assign fetch_addr = ADDR_WIDTH'(i_ring_base) + ADDR_WIDTH'({head, 4'b0000});

   // A well-formed burst has rlast on beat 3 only, with OKAY on every beat.
   assign beat_bad  = (bus.rresp != AXI_RESP_OKAY) || (bus.rlast != (beat_cnt == 2'd3));
   assign beat_last = bus.rlast || (beat_cnt == 2'd3);
   assign abort_req = !i_enable || i_ring_init;
   assign init_any  = init_pend || i_ring_init;

   assign bus.arlen   = AXI_LEN_DESC;
   assign bus.arsize  = AXI_SIZE_4B;
   assign bus.arburst = AXI_BURST_INCR;

   assign o_hw_head_ptr = head;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         head           <= '0;
         beat_cnt       <= '0;
         burst_err      <= 1'b0;
         discard        <= 1'b0;
         init_pend      <= 1'b0;
         o_fetch_err    <= 1'b0;
         o_busy         <= 1'b0;
         bus.araddr     <= '0;
         bus.arvalid    <= 1'b0;
         bus.rready     <= 1'b0;
         bus.desc_valid <= 1'b0;
         bus.desc       <= '0;
         for (int i = 0; i < DESC_BEATS; i++) word[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               init_pend <= 1'b0;
               discard   <= 1'b0;
               if (i_ring_init) begin
                  head <= '0;
               end else if (i_enable && (head != i_sw_tail_ptr)) begin
                  o_busy <= 1'b1;
                  if (cfg_bad) begin
                     o_fetch_err <= 1'b1;
                     state       <= ST_ERROR;
                  end else begin
                     bus.araddr  <= fetch_addr;
                     bus.arvalid <= 1'b1;
                     state       <= ST_AR;
                  end
               end
            end

            ST_AR: begin
               if (abort_req)   discard   <= 1'b1;
               if (i_ring_init) init_pend <= 1'b1;
               if (bus.arready) begin
                  bus.arvalid <= 1'b0;
                  bus.rready  <= 1'b1;
                  beat_cnt    <= '0;
                  burst_err   <= 1'b0;
                  state       <= ST_RDATA;
               end
            end

            // The burst is always drained to its last beat, even when it will be dropped.
            ST_RDATA: begin
               if (abort_req)   discard   <= 1'b1;
               if (i_ring_init) init_pend <= 1'b1;
               if (bus.rvalid) begin
                  word[beat_cnt] <= bus.rdata;
                  if (beat_bad) burst_err <= 1'b1;
                  if (beat_last) begin
                     bus.rready <= 1'b0;
                     if (burst_err || beat_bad) begin
                        o_fetch_err <= 1'b1;
                        state       <= ST_ERROR;
                     end else if (discard || abort_req) begin
                        if (init_any) head <= '0;
                        init_pend <= 1'b0;
                        o_busy    <= 1'b0;
                        state     <= ST_IDLE;
                     end else begin
                        bus.desc_valid <= 1'b1;
                        bus.desc       <= '{user: bus.rdata, ctrl: word[2], len: word[1], src_addr: word[0]};
                        state          <= ST_PRESENT;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 2'd1;
                  end
               end
            end

            ST_PRESENT: begin
               if (i_ring_init) init_pend <= 1'b1;
               if (bus.desc_ready) begin
                  bus.desc_valid <= 1'b0;
                  head           <= init_any ? '0 : head_adv;
                  init_pend      <= 1'b0;
                  o_busy         <= 1'b0;
                  state          <= ST_IDLE;
               end
            end

            ST_ERROR: begin
               if (i_ring_init) head <= '0;
               if (!i_enable) begin
                  if (init_pend) head <= '0;
                  init_pend   <= 1'b0;
                  o_fetch_err <= 1'b0;
                  o_busy      <= 1'b0;
                  state       <= ST_IDLE;
               end
            end

            default: begin
               state  <= ST_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_desc_ring_fetch.sv
// Scoreboarded bench: directed ring scenarios with an AXI memory responder and decoupled monitors.
module tb_desc_ring_fetch;
   import desc_ring_fetch_pkg::*;

   localparam logic [127:0] DESC0 = 128'hD5C0100C_D5C01008_D5C01004_D5C01000;
   localparam logic [127:0] DESC1 = 128'hD5C0101C_D5C01018_D5C01014_D5C01010;
   localparam logic [127:0] DESC2 = 128'hD5C0102C_D5C01028_D5C01024_D5C01020;
   localparam logic [127:0] DESC3 = 128'hD5C0103C_D5C01038_D5C01034_D5C01030;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        ring_init;
   logic [31:0] ring_base;
   logic [31:0] ring_size;
   logic [15:0] sw_tail;
   logic [15:0] hw_head;
   logic        fetch_err;
   logic        busy;

   desc_ring_fetch_if #(.ADDR_WIDTH(32)) bus ();

   desc_ring_fetch #(.ADDR_WIDTH(32), .PTR_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_enable     (enable),
      .i_ring_init  (ring_init),
      .i_ring_base  (ring_base),
      .i_ring_size  (ring_size),
      .i_sw_tail_ptr(sw_tail),
      .o_hw_head_ptr(hw_head),
      .o_fetch_err  (fetch_err),
      .o_busy       (busy),
      .bus          (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int ar_cnt   = 0;
   int beats_sent = 0;
   int err_beat = -1;

   logic [31:0]  exp_ar   [$];
   logic [127:0] exp_desc [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic wait_head(input string name, input logic [15:0] req, input int budget);
      int k;
      k = 0;
      while (!(hw_head == req && !busy) && k < budget) begin
         tick();
         k++;
      end
      if (k >= budget) timeout_fail(name);
      else check(name, 128'(hw_head), 128'(req));
   endtask

   task automatic wait_err(input string name, input int budget);
      int k;
      k = 0;
      while (!fetch_err && k < budget) begin
         tick();
         k++;
      end
      if (k >= budget) timeout_fail(name);
   endtask

   // Memory responder: word at address A holds {16'hD5C0, A[15:0]}.
   initial begin
      logic [31:0] addr;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rdata   = '0;
      bus.rresp   = 2'b00;
      bus.rlast   = 1'b0;
      forever begin
         tick();
         if (bus.arvalid) begin
            bus.arready = 1'b1;
            addr = bus.araddr;
            tick();
            bus.arready = 1'b0;
            for (int b = 0; b < 4; b++) begin
               bus.rvalid = 1'b1;
               bus.rdata  = {16'hD5C0, addr[15:0] + 16'(4 * b)};
               bus.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
               bus.rlast  = (b == 3);
               while (!bus.rready) tick();
               @(posedge clk);
               beats_sent++;
               #1;
            end
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
            bus.rresp  = 2'b00;
         end
      end
   end

   // Monitors: pop the scoreboard whenever a handshake completes.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.arvalid && bus.arready) begin
            ar_cnt++;
            if (exp_ar.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_ar: got %0h, required no AR", bus.araddr);
            end else begin
               check("ar_addr", 128'(bus.araddr), 128'(exp_ar.pop_front()));
            end
            check("ar_len_size_burst", 128'({bus.arlen, bus.arsize, bus.arburst}),
                  128'({8'd3, 3'b010, 2'b01}));
         end
         if (bus.desc_valid && bus.desc_ready) begin
            if (exp_desc.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_desc: got %0h, required no descriptor", bus.desc);
            end else begin
               check("desc_data", bus.desc, exp_desc.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int held_bad;
      int ar_snap;
      int beat_snap;
      int k;

      rst_n          = 1'b0;
      enable         = 1'b0;
      ring_init      = 1'b0;
      ring_base      = 32'h1000;
      ring_size      = 32'd4;
      sw_tail        = 16'd0;
      bus.desc_ready = 1'b1;
      repeat (3) tick();

      check("rst_head", 128'(hw_head), 128'(0));
      check("rst_err_busy", 128'({fetch_err, busy}), 128'(0));
      check("rst_valids", 128'({bus.arvalid, bus.rready, bus.desc_valid}), 128'(0));
      check("rst_desc", bus.desc, 128'(0));
      rst_n = 1'b1;

      // T1: two descriptors from the start of the ring
      enable = 1'b1;
      repeat (5) tick();
      check("t1_idle_no_ar", 128'(ar_cnt), 128'(0));
      exp_ar.push_back(32'h1000);   exp_desc.push_back(DESC0);
      exp_ar.push_back(32'h1010);   exp_desc.push_back(DESC1);
      sw_tail = 16'd2;
      wait_head("t1_head", 16'd2, 100);

      // T2: wrap past the end of a 4-entry ring
      exp_ar.push_back(32'h1020);   exp_desc.push_back(DESC2);
      sw_tail = 16'd3;
      wait_head("t2_head3", 16'd3, 100);
      exp_ar.push_back(32'h1030);   exp_desc.push_back(DESC3);
      exp_ar.push_back(32'h1000);   exp_desc.push_back(DESC0);
      sw_tail = 16'd1;
      wait_head("t2_head_wrap", 16'd1, 100);

      // T3: DMA backpressure holds the descriptor
      bus.desc_ready = 1'b0;
      exp_ar.push_back(32'h1010);   exp_desc.push_back(DESC1);
      sw_tail = 16'd2;
      k = 0;
      while (!bus.desc_valid && k < 100) begin tick(); k++; end
      if (k >= 100) timeout_fail("t3_valid_rise");
      ar_snap  = ar_cnt;
      held_bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!bus.desc_valid || bus.desc !== DESC1) held_bad++;
      end
      check("t3_valid_stable", 128'(held_bad), 128'(0));
      check("t3_head_held", 128'(hw_head), 128'(1));
      check("t3_no_new_ar", 128'(ar_cnt), 128'(ar_snap));
      bus.desc_ready = 1'b1;
      wait_head("t3_head", 16'd2, 100);

      // T4: SLVERR on beat 2 is drained then reported
      err_beat  = 2;
      beat_snap = beats_sent;
      exp_ar.push_back(32'h1020);
      sw_tail = 16'd3;
      wait_err("t4_err_rise", 100);
      check("t4_beats_drained", 128'(beats_sent - beat_snap), 128'(4));
      check("t4_head_frozen", 128'(hw_head), 128'(2));
      check("t4_err_busy", 128'({fetch_err, busy}), 128'(2'b11));
      repeat (5) tick();
      check("t4_err_sticky", 128'(fetch_err), 128'(1));
      enable = 1'b0;
      repeat (2) tick();
      check("t4_err_cleared", 128'({fetch_err, busy}), 128'(0));
      err_beat = -1;
      exp_ar.push_back(32'h1020);   exp_desc.push_back(DESC2);
      enable = 1'b1;
      wait_head("t4_refetch", 16'd3, 100);

      // T5: bad configuration never issues an AR
      ar_snap = ar_cnt;
      sw_tail = 16'd5;
      wait_err("t5_tail_err", 50);
      repeat (5) tick();
      check("t5_tail_no_ar", 128'(ar_cnt), 128'(ar_snap));
      check("t5_tail_err", 128'(fetch_err), 128'(1));
      enable = 1'b0;
      sw_tail = 16'd3;
      repeat (2) tick();
      check("t5_err_cleared", 128'(fetch_err), 128'(0));
      ring_base = 32'h1004;
      sw_tail   = 16'd0;
      enable    = 1'b1;
      wait_err("t5_base_err", 50);
      repeat (5) tick();
      check("t5_base_no_ar", 128'(ar_cnt), 128'(ar_snap));
      check("t5_base_head", 128'(hw_head), 128'(3));
      enable = 1'b0;
      tick();
      ring_base = 32'h1000;

      // T6: init while a burst is in flight drops it and restarts from base
      ring_init = 1'b1;
      tick();
      ring_init = 1'b0;
      tick();
      check("t6_idle_init", 128'(hw_head), 128'(0));
      exp_ar.push_back(32'h1000);   exp_desc.push_back(DESC0);
      exp_ar.push_back(32'h1010);   exp_desc.push_back(DESC1);
      sw_tail = 16'd2;
      enable  = 1'b1;
      wait_head("t6_head2", 16'd2, 100);
      exp_ar.push_back(32'h1020);
      exp_ar.push_back(32'h1000);   exp_desc.push_back(DESC0);
      exp_ar.push_back(32'h1010);   exp_desc.push_back(DESC1);
      exp_ar.push_back(32'h1020);   exp_desc.push_back(DESC2);
      beat_snap = beats_sent;
      sw_tail   = 16'd3;
      k = 0;
      while (!bus.rready && k < 50) begin tick(); k++; end
      if (k >= 50) timeout_fail("t6_rready");
      ring_init = 1'b1;
      tick();
      ring_init = 1'b0;
      k = 0;
      while (busy && k < 50) begin tick(); k++; end
      if (k >= 50) timeout_fail("t6_discard_idle");
      check("t6_head_reset", 128'(hw_head), 128'(0));
      check("t6_beats_drained", 128'(beats_sent - beat_snap), 128'(4));
      wait_head("t6_refetch", 16'd3, 200);

      repeat (3) tick();
      check("ar_queue_empty", 128'(exp_ar.size()), 128'(0));
      check("desc_queue_empty", 128'(exp_desc.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
